bcd_display_scan: RTL
=====================

BCD_DISPLAY_SCAN -- requirements
Module: bcd_display_scan

Interface
REQ-001 The block SHALL take one clock and an asynchronous, active-high reset, and SHALL name its ports as below.
REQ-002 The block SHALL have parameter REFRESH_DIV, default 100000, giving the number of clk cycles each digit is shown (1 kHz per digit at 100 MHz); legal values are 2 or more.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 bcd  input  16  four packed BCD digits from the binary-to-BCD converter; [3:0] is units (digit 0), [15:12] is thousands (digit 3).
REQ-006 load  input  1  when high on a clk edge, bcd is captured.
REQ-007 blank_lz  input  1  when high, leading zeros are blanked.
REQ-008 an  output  4  digit enables, active-low, one-hot-low; an[i] drives digit i.
REQ-009 seg  output  7  segments, active-low, ordered {g,f,e,d,c,b,a}.

Function
REQ-010 A prescaler SHALL count 0..REFRESH_DIV-1 and wrap; tick SHALL be high in the cycle the count equals REFRESH_DIV-1.
REQ-011 A 2-bit digit index SHALL advance 0->1->2->3->0 on each tick; one frame is 4*REFRESH_DIV cycles.
REQ-012 On load=1, bcd SHALL be written into a shadow register and a pending flag SHALL be set.
REQ-013 The display register SHALL update only at a frame boundary (tick with index=3). If pending=1, it takes the shadow value and pending clears; otherwise it is unchanged.
REQ-014 If load=1 in the boundary cycle itself, the display register SHALL take bcd directly and pending SHALL end cleared.
REQ-015 an and seg SHALL be registered. Their values in cycle n+1 reflect the digit index and display register in cycle n (1-cycle latency).
REQ-016 an SHALL equal ~(4'b0001 << index); exactly one bit is low outside reset.
REQ-017 Segment codes SHALL be: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10.
REQ-018 A nibble of 10..15 SHALL display a dash (0x3F); it never counts as a zero for blanking.
REQ-019 With blank_lz=1, digit i (i=3..1) SHALL show blank (0x7F) when it and all higher digits are 0. Digit 0 SHALL never be blanked.
REQ-020 With blank_lz=0, all four digits SHALL be decoded per REQ-017/REQ-018.
REQ-021 blank_lz SHALL act immediately on the registered outputs; it is not frame-synchronised.

Reset
REQ-022 While rst=1: an=4'b1111, seg=7'h7F, prescaler=0, index=0, shadow=0, display register=0, pending=0.
REQ-023 In the first edge after rst falls, the block SHALL drive an=4'b1110 and seg=0x40.
REQ-024 Reset asserted mid-frame SHALL abort the scan immediately, with no stale digit driven, and any pending load SHALL be discarded.

Structure
REQ-025 The ten digit codes, the dash and blank codes, and the all-off an value SHALL live in shared package bcd_display_pkg, which the balance top level reuses.
REQ-026 BCD-to-segment decoding SHALL be a combinational sub-module seg7_decoder, with inputs a nibble and a blank flag and output seg[6:0].
REQ-027 The prescaler, index, shadow/pending logic, blanking logic and output registers SHALL stay in bcd_display_scan.

Verification (REFRESH_DIV=4)
REQ-028 load bcd=16'h1000, blank_lz=1, after one boundary -> digit 3 shows 0x79, digits 2..0 show 0x40.
REQ-029 load bcd=16'h0042, blank_lz=1 -> digits 3 and 2 show 0x7F, digit 1 shows 0x19, digit 0 shows 0x24. Setting blank_lz=0 -> digits 3 and 2 show 0x40 on the next cycle.
REQ-030 load bcd=16'h0000, blank_lz=1 -> digit 0 shows 0x40, digits 3..1 show 0x7F. load bcd=16'h00A5 -> digit 1 shows 0x3F.
REQ-031 load 16'h1234 while index=1, then load 16'h5678 while index=2 -> the display keeps its old value until the index 3->0 wrap, then shows 5678. Also: load in the boundary cycle -> that value is shown in the next frame.
REQ-032 Assert rst while index=2 -> an=4'b1111 and seg=7'h7F in the same cycle. After release -> digit 0 shows 0x40 and no pending value appears.
REQ-033 In every test, check that an is one-hot-low outside reset and that each digit lasts exactly 4 cycles.

Source files
------------

// File: rtl/bcd_display_pkg.sv
// Shared seven-segment constants for the display scanners (active-low, {g,f,e,d,c,b,a}).
// Also reused by the balance top level.
package bcd_display_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] AN_OFF    = 4'hF;

  typedef enum logic [1:0] {
    DIGIT0,
    DIGIT1,
    DIGIT2,
    DIGIT3
  } digit_t;

  // Non-decimal nibbles show a dash so a converter fault is visible on the panel.
  function automatic logic [6:0] digit_code(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_DASH;
    endcase
    return code;
  endfunction

  function automatic logic [3:0] digit_enable(input digit_t d);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << d);
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD nibble to active-low seven-segment decoder with blank override.
module seg7_decoder
  import bcd_display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = digit_code(nibble);
    if (blank) begin
      seg = SEG_BLANK;
    end
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Four-digit multiplexed BCD display scanner with frame-synchronised updates and
// optional leading-zero blanking; an/seg are registered.
module bcd_display_scan
  import bcd_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd,
  input  logic        load,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] PRESCALE_MAX = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] prescale;
  logic          tick;
  logic          boundary;
  digit_t        idx;

  logic [15:0]   shadow;
  logic [15:0]   disp;
  logic          pending;

  logic [3:0]    zero;
  logic [3:0]    leading;
  logic [3:0]    cur_nib;
  logic          cur_blank;
  logic [6:0]    seg_next;
  logic [3:0]    an_next;

  assign tick     = (prescale == PRESCALE_MAX);
  assign boundary = tick && (idx == DIGIT3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale <= '0;
      idx      <= DIGIT0;
    end else begin
      if (tick) begin
        prescale <= '0;
        idx      <= digit_t'(idx + 2'd1);
      end else begin
        prescale <= prescale + CW'(1);
      end
    end
  end

  // A load landing on the frame boundary bypasses the shadow so it is not lost
  // and cannot leave a stale pending flag behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= '0;
      disp    <= '0;
      pending <= 1'b0;
    end else begin
      if (load) begin
        shadow <= bcd;
      end
      if (boundary) begin
        pending <= 1'b0;
        if (load) begin
          disp <= bcd;
        end else if (pending) begin
          disp <= shadow;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  always_comb begin
    zero = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      zero[i] = (disp[4*i +: 4] == 4'd0);
    end
    leading    = '0;
    leading[3] = zero[3];
    leading[2] = leading[3] & zero[2];
    leading[1] = leading[2] & zero[1];
  end

  always_comb begin
    cur_nib = disp[3:0];
    case (idx)
      DIGIT0:  cur_nib = disp[3:0];
      DIGIT1:  cur_nib = disp[7:4];
      DIGIT2:  cur_nib = disp[11:8];
      DIGIT3:  cur_nib = disp[15:12];
      default: cur_nib = disp[3:0];
    endcase
    cur_blank = blank_lz & leading[idx];
    an_next   = digit_enable(idx);
  end

  seg7_decoder u_decoder (
    .nibble (cur_nib),
    .blank  (cur_blank),
    .seg    (seg_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule
